// File: rtl/store_write_buffer.sv
// Posted-write FIFO between the core store path and data memory, with load forwarding.
// Latency: a pushed store is presented to memory the cycle after the push; lookup is combinational.
// Backpressure: st_ready drops only when full; entries drain one per cycle that mem_ack is high.
module store_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   st_valid,
  input  logic [AW-1:0]          st_addr,
  input  logic [DW-1:0]          st_data,
  output logic                   st_ready,
  input  logic [AW-1:0]          ld_addr,
  output logic                   ld_hit,
  output logic [DW-1:0]          ld_data,
  output logic                   mem_we,
  output logic [AW-1:0]          mem_addr,
  output logic [DW-1:0]          mem_wdata,
  input  logic                   mem_ack,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Entry storage; addresses are kept word-aligned so the head can drive memory directly.
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push;
  logic          pop;
  logic [PW-1:0] fwd_idx;

  // Status depends only on occupancy, so st_ready has no path from mem_ack.
  assign st_ready  = (count_q != CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign mem_we    = !empty;
  assign mem_addr  = addr_q[rd_ptr_q];
  assign mem_wdata = data_q[rd_ptr_q];
  assign count     = count_q;

  assign push = st_valid && st_ready;
  assign pop  = mem_we && mem_ack;

  // Next pointer and occupancy values from this cycle's push/pop.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards everything pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry write on push; stale contents are harmless because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= {st_addr[AW-1:2], 2'b00};
      data_q[wr_ptr_q] <= st_data;
    end
  end

  // Walk valid entries oldest to youngest from the head so the last match wins,
  // which keeps age order correct across pointer wrap. A same-cycle push is not visible.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    fwd_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = rd_ptr_q + PW'(k);
      if ((CW'(k) < count_q) && (addr_q[fwd_idx][AW-1:2] == ld_addr[AW-1:2])) begin
        ld_hit  = 1'b1;
        ld_data = data_q[fwd_idx];
      end
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: directed scenarios plus randomized traffic against a queue model.
// Outputs are checked every cycle at the falling edge; inputs change 1 time unit after the rising edge.
// The model is a plain queue of pending stores plus a log of expected memory writes.
module tb_store_write_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          st_ready;
  logic [AW-1:0] ld_addr;
  logic          ld_hit;
  logic [DW-1:0] ld_data;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic          empty;
  logic [2:0]    count;

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_en = 1'b0;
  ent_t mq[$];
  ent_t exp_wr[$];
  ent_t dut_wr[$];
  logic [DW-1:0] dmem [logic [AW-1:0]];

  store_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic ack);
    st_valid = v;
    st_addr  = a;
    st_data  = d;
    mem_ack  = ack;
  endtask

  // Reference model: a reset empties the queue; otherwise pop the head on ack, append on accept.
  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
    end else begin
      bit do_push;
      do_push = st_valid && (mq.size() < DEPTH);
      if (mem_ack && mq.size() > 0) begin
        exp_wr.push_back(mq[0]);
        void'(mq.pop_front());
      end
      if (do_push) mq.push_back('{a: {st_addr[AW-1:2], 2'b00}, d: st_data});
    end
  end

  // Memory side as seen from the DUT: log every accepted write and keep a word array.
  always @(posedge clk) begin
    if (chk_en && !reset && mem_we && mem_ack) begin
      dut_wr.push_back('{a: mem_addr, d: mem_wdata});
      dmem[mem_addr] = mem_wdata;
    end
  end

  // Per-cycle comparison of every output against the queue model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic          e_hit;
      logic [DW-1:0] e_ld;
      e_hit = 1'b0;
      e_ld  = '0;
      for (int i = 0; i < mq.size(); i++) begin
        if (mq[i].a[AW-1:2] == ld_addr[AW-1:2]) begin
          e_hit = 1'b1;
          e_ld  = mq[i].d;
        end
      end
      chk("st_ready", 64'(st_ready), 64'(mq.size() < DEPTH));
      chk("empty",    64'(empty),    64'(mq.size() == 0));
      chk("count",    64'(count),    64'(mq.size()));
      chk("mem_we",   64'(mem_we),   64'(mq.size() > 0));
      chk("ld_hit",   64'(ld_hit),   64'(e_hit));
      chk("ld_data",  64'(ld_data),  64'(e_ld));
      if (mq.size() > 0) begin
        chk("mem_addr",  64'(mem_addr),  64'(mq[0].a));
        chk("mem_wdata", 64'(mem_wdata), 64'(mq[0].d));
      end
    end
  end

  initial begin
    int base;
    reset    = 1'b1;
    ld_addr  = '0;
    drive(1'b0, '0, '0, 1'b0);

    // Reset, then idle three cycles.
    cyc();
    chk_en = 1'b1;
    cyc();
    reset = 1'b0;
    cyc(); cyc(); cyc();
    chk("rst_empty",    64'(empty),    64'd1);
    chk("rst_count",    64'(count),    64'd0);
    chk("rst_st_ready", 64'(st_ready), 64'd1);
    chk("rst_mem_we",   64'(mem_we),   64'd0);
    chk("rst_ld_hit",   64'(ld_hit),   64'd0);
    chk("rst_ld_data",  64'(ld_data),  64'd0);

    // Single store, held, then acked once.
    base = dut_wr.size();
    drive(1'b1, 32'h10, 32'hAAAA, 1'b0);
    cyc();
    drive(1'b0, '0, '0, 1'b0);
    chk("one_mem_we",    64'(mem_we),    64'd1);
    chk("one_mem_addr",  64'(mem_addr),  64'h10);
    chk("one_mem_wdata", 64'(mem_wdata), 64'hAAAA);
    chk("one_count",     64'(count),     64'd1);
    cyc();
    chk("one_still_held", 64'(count), 64'd1);
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    chk("one_empty",  64'(empty), 64'd1);
    chk("one_nwrite", 64'(dut_wr.size() - base), 64'd1);
    chk("one_waddr",  64'(dut_wr[base].a), 64'h10);
    chk("one_wdata",  64'(dut_wr[base].d), 64'hAAAA);

    // Fill to full; a fifth store is dropped.
    base = dut_wr.size();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i), 32'(i + 1), 1'b0);
      cyc();
    end
    chk("full_st_ready", 64'(st_ready), 64'd0);
    chk("full_count",    64'(count),    64'd4);
    drive(1'b1, 32'h10, 32'd5, 1'b0);
    cyc();
    chk("full_drop_count", 64'(count), 64'd4);
    drive(1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 4; i++) cyc();
    mem_ack = 1'b0;
    cyc();
    chk("full_nwrite", 64'(dut_wr.size() - base), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < dut_wr.size()) begin
        chk("full_order_addr", 64'(dut_wr[base + i].a), 64'(4 * i));
        chk("full_order_data", 64'(dut_wr[base + i].d), 64'(i + 1));
      end
    end
    chk("full_empty", 64'(empty), 64'd1);

    // Forwarding of the youngest match, through two drains.
    drive(1'b1, 32'h20, 32'd7, 1'b0);
    cyc();
    drive(1'b1, 32'h20, 32'd9, 1'b0);
    cyc();
    drive(1'b0, '0, '0, 1'b0);
    ld_addr = 32'h22;
    #1;
    chk("fwd_hit",  64'(ld_hit),  64'd1);
    chk("fwd_data", 64'(ld_data), 64'd9);
    ld_addr = 32'h24;
    #1;
    chk("fwd_miss_hit",  64'(ld_hit),  64'd0);
    chk("fwd_miss_data", 64'(ld_data), 64'd0);
    ld_addr = 32'h22;
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    chk("fwd_ack1_hit",  64'(ld_hit),  64'd1);
    chk("fwd_ack1_data", 64'(ld_data), 64'd9);
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    chk("fwd_ack2_hit", 64'(ld_hit), 64'd0);

    // Simultaneous push and pop at count=2 across pointer wrap.
    base = dut_wr.size();
    drive(1'b1, 32'h40, 32'd1, 1'b0);
    cyc();
    drive(1'b1, 32'h44, 32'd2, 1'b0);
    cyc();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(32'h48 + 4 * i), 32'(100 + i), 1'b1);
      cyc();
      chk("pp_count", 64'(count), 64'd2);
    end
    drive(1'b0, '0, '0, 1'b0);
    ld_addr = 32'h6C;
    #1;
    chk("pp_fwd_hit",  64'(ld_hit),  64'd1);
    chk("pp_fwd_data", 64'(ld_data), 64'd109);
    chk("pp_nwrite",   64'(dut_wr.size() - base), 64'd10);
    if (dut_wr.size() == base + 10) begin
      chk("pp_last_addr", 64'(dut_wr[base + 9].a), 64'h64);
      chk("pp_last_data", 64'(dut_wr[base + 9].d), 64'd107);
    end
    mem_ack = 1'b1;
    for (int i = 0; i < 10 && !empty; i++) cyc();
    mem_ack = 1'b0;
    chk("pp_drained", 64'(empty), 64'd1);

    // Reset in the middle of a drain with three entries pending.
    dmem.delete();
    base = dut_wr.size();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(32'h80 + 4 * i), 32'(32'hC0 + i), 1'b0);
      cyc();
    end
    drive(1'b0, '0, '0, 1'b1);
    cyc();
    mem_ack = 1'b0;
    chk("mid_count", 64'(count), 64'd3);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("mid_empty",  64'(empty),  64'd1);
    chk("mid_mem_we", 64'(mem_we), 64'd0);
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    mem_ack = 1'b0;
    chk("mid_nwrite", 64'(dut_wr.size() - base), 64'd1);
    chk("mid_dump_80", dmem.exists(32'h80) ? 64'(dmem[32'h80]) : 64'hDEAD, 64'hC0);
    chk("mid_dump_84", 64'(dmem.exists(32'h84)), 64'd0);
    chk("mid_dump_88", 64'(dmem.exists(32'h88)), 64'd0);
    chk("mid_dump_8C", 64'(dmem.exists(32'h8C)), 64'd0);

    // Randomized traffic with occasional resets; model checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      reset    = ($urandom_range(0, 299) == 0);
      st_valid = ($urandom_range(0, 99) < 60);
      st_addr  = 32'(($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
      st_data  = $urandom;
      mem_ack  = reset ? 1'b0 : ($urandom_range(0, 99) < 45);
      ld_addr  = 32'(($urandom_range(0, 8) << 2) | $urandom_range(0, 3));
      cyc();
    end
    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    cyc();

    // Every write the memory saw must match the model's write stream exactly.
    chk("wr_log_size", 64'(dut_wr.size()), 64'(exp_wr.size()));
    for (int i = 0; i < dut_wr.size() && i < exp_wr.size(); i++) begin
      if (dut_wr[i].a !== exp_wr[i].a || dut_wr[i].d !== exp_wr[i].d) begin
        chk("wr_log_entry", {dut_wr[i].a, dut_wr[i].d}, {exp_wr[i].a, exp_wr[i].d});
        break;
      end
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Posted-write FIFO between the single-cycle core's store path and the data memory word array.
- Stores retire from the core in one cycle and drain to memory one per accepted beat.
- Loads check the buffer first and forward the youngest matching pending store, so a load never sees stale memory data.
- Decouples core store timing from memory write acceptance, which is either multi-cycle or back-pressured.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, at least 2.
- AW, 32, byte address width from the core.
- DW, 32, data word width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; clears all buffer state.
- st_valid  input  1  core presents a store this cycle.
- st_addr  input  AW  store byte address; bits [1:0] ignored (word access only).
- st_data  input  DW  store data.
- st_ready  output  1  buffer can accept a store; equals !full.
- ld_addr  input  AW  load byte address for the forwarding lookup; bits [1:0] ignored.
- ld_hit  output  1  a pending entry matches ld_addr.
- ld_data  output  DW  data of the youngest matching entry; 0 when ld_hit=0.
- mem_we  output  1  head entry is valid and presented to memory.
- mem_addr  output  AW  head entry address, with bits [1:0] forced to 0.
- mem_wdata  output  DW  head entry data.
- mem_ack  input  1  memory accepts the presented write this cycle.
- empty  output  1  no pending stores; the core uses it as a fence or drain-complete signal.
- count  output  $clog2(DEPTH)+1  number of pending entries.

Behaviour:
- Storage: circular array of DEPTH {addr, data} entries.
  - Pointers: wr_ptr and rd_ptr, each $clog2(DEPTH) bits, both wrapping modulo DEPTH.
  - Occupancy: count register, 0..DEPTH.
  - full = (count==DEPTH); empty = (count==0).
- Reset (synchronous, active-high):
  - wr_ptr=0, rd_ptr=0, count=0.
  - Outputs after reset: st_ready=1, empty=1, mem_we=0, ld_hit=0, ld_data=0.
  - mem_addr and mem_wdata are don't-care while mem_we=0; the bench checks them only when mem_we=1.
  - Reset mid-operation discards all pending stores; none are written to memory. Reset overrides push and pop in the same cycle.
- Push: push = st_valid && st_ready.
  - At the clock edge, entry[wr_ptr] <= {st_addr, st_data} and wr_ptr increments.
  - st_valid while full is ignored; the core must stall on st_ready=0.
  - st_ready depends only on count. It has no combinational path from mem_ack.
- Pop: pop = mem_we && mem_ack, where mem_we = !empty.
  - mem_addr and mem_wdata come combinationally from entry[rd_ptr].
  - On pop, rd_ptr increments at the edge.
  - mem_ack while empty is ignored.
- Simultaneous push and pop: both take effect and count is unchanged.
  - When full, push is blocked even if a pop occurs that cycle; the freed slot is visible next cycle.
  - When empty, a pushed store is not presented the same cycle. mem_we rises the cycle after the push (one-cycle minimum write latency).
- Count update:
  - push only: +1.
  - pop only: -1.
  - both or neither: unchanged.
- Ordering: memory writes leave in strict FIFO order. No coalescing; duplicate addresses occupy separate entries.
- Forwarding (combinational):
  - Compare ld_addr[AW-1:2] against every valid entry.
  - Valid entries are the count entries starting at rd_ptr.
  - ld_data is the data of the youngest match, i.e. closest to wr_ptr-1.
  - The store being pushed in the current cycle is NOT visible to the lookup; the core already bypasses same-cycle stores.
  - The head entry being popped this cycle IS still visible this cycle.
- Wrap-around: pointers wrap from DEPTH-1 to 0. The forwarding age order must remain correct across the wrap.

Test Plan:
- Reset then idle 3 cycles -> empty=1, count=0, st_ready=1, mem_we=0, ld_hit=0.
- Push 0x10/0xAAAA with mem_ack=0 held -> next cycle mem_we=1, mem_addr=0x10, mem_wdata=0xAAAA, count=1. Raise mem_ack one cycle -> empty=1 next cycle, exactly one write observed.
- Fill to full with mem_ack=0: 0x0/1, 0x4/2, 0x8/3, 0xC/4 -> st_ready=0. A 5th store 0x10/5 is dropped. Then ack 4 cycles -> writes in order (0x0,1),(0x4,2),(0x8,3),(0xC,4); 0x10 is never written.
- Forwarding: push 0x20/7 then 0x20/9 with no ack -> ld_addr=0x22 gives ld_hit=1, ld_data=9; ld_addr=0x24 gives ld_hit=0, ld_data=0. After one ack, ld_data is still 9; after two acks, ld_hit=0.
- Simultaneous push and pop at count=2 with mem_ack=1 and st_valid=1 -> count stays 2. Run 10 such cycles to force pointer wrap -> FIFO order and forwarding stay correct.
- Reset asserted with count=3 mid-drain -> next cycle empty=1, mem_we=0. No further writes to memory; a data-memory dump shows only pre-reset acked words.
